// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and address-decode result codes.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } slv_state_e;

  typedef enum logic [2:0] {
    DEC_OK,
    DEC_MISALIGN,
    DEC_BELOW_BASE,
    DEC_OUT_OF_RANGE,
    DEC_READ_ONLY
  } dec_err_e;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational word-address decode for APB register slaves: address -> register index and error flag.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int              NUM_REGS  = 16,
  parameter logic [APB_AW-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [APB_AW-1:0] paddr,
  input  logic              pwrite,
  output logic [7:0]        idx,
  output logic              err
);

  logic [APB_AW-1:0] offset;
  logic [29:0]       word;
  dec_err_e          code;

  // Subtraction wraps below base; the explicit compare catches that case first.
  always_comb begin
    offset = paddr - BASE_ADDR;
    word   = 30'(offset >> 2);
    code   = DEC_OK;
    if (paddr[1:0] != 2'b00) begin
      code = DEC_MISALIGN;
    end else if (paddr < BASE_ADDR) begin
      code = DEC_BELOW_BASE;
    end else if (word >= 30'(NUM_REGS)) begin
      code = DEC_OUT_OF_RANGE;
    end else if (pwrite && (word == '0)) begin
      code = DEC_READ_ONLY;
    end
  end

  assign idx = word[7:0];
  assign err = (code != DEC_OK);

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 completer with a small register file (index 0 = read-only ID), programmable wait
// states and a one-cycle write-event strobe. All bus outputs are registered.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int                NUM_REGS    = 16,
  parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                WAIT_STATES = 2,
  parameter logic [APB_DW-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [APB_AW-1:0] PADDR,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              o_wr_pulse,
  output logic [7:0]        o_wr_idx,
  output logic [APB_DW-1:0] o_wr_data
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  slv_state_e        state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [7:0]        lat_idx_reg, lat_idx_next;
  logic              lat_write_reg, lat_write_next;
  logic              lat_err_reg, lat_err_next;
  logic [APB_DW-1:0] lat_wdata_reg, lat_wdata_next;

  logic [APB_DW-1:0] prdata_next;
  logic              pready_next, pslverr_next;
  logic              wr_pulse_next;
  logic [7:0]        wr_idx_next;
  logic [APB_DW-1:0] wr_data_next;
  logic              commit;

  logic [APB_DW-1:0] regs_reg [NUM_REGS];

  logic [7:0]        dec_idx;
  logic              dec_err;
  logic [APB_DW-1:0] rd_dec, rd_lat;

  apb_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .paddr  (PADDR),
    .pwrite (PWRITE),
    .idx    (dec_idx),
    .err    (dec_err)
  );

  // Read data for the zero-wait path (live decode) and the waited path (latched decode).
  assign rd_dec = (dec_idx == 8'd0) ? ID_VALUE : regs_reg[dec_idx[IDX_W-1:0]];
  assign rd_lat = (lat_idx_reg == 8'd0) ? ID_VALUE : regs_reg[lat_idx_reg[IDX_W-1:0]];

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    lat_idx_next   = lat_idx_reg;
    lat_write_next = lat_write_reg;
    lat_err_next   = lat_err_reg;
    lat_wdata_next = lat_wdata_reg;
    prdata_next    = '0;
    pready_next    = 1'b0;
    pslverr_next   = 1'b0;
    wr_pulse_next  = 1'b0;
    wr_idx_next    = o_wr_idx;
    wr_data_next   = o_wr_data;
    commit         = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (PSELx && !PENABLE) begin
          lat_idx_next   = dec_idx;
          lat_write_next = PWRITE;
          lat_err_next   = dec_err;
          lat_wdata_next = PWDATA;
          if (WAIT_STATES == 0) begin
            state_next   = S_RESP;
            pready_next  = 1'b1;
            pslverr_next = dec_err;
            prdata_next  = (PWRITE || dec_err) ? '0 : rd_dec;
          end else begin
            state_next = S_WAIT;
            cnt_next   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!PSELx) begin
          state_next = S_IDLE;
        end else if (cnt_reg == 4'd0) begin
          state_next   = S_RESP;
          pready_next  = 1'b1;
          pslverr_next = lat_err_reg;
          prdata_next  = (lat_write_reg || lat_err_reg) ? '0 : rd_lat;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
        if (lat_write_reg && !lat_err_reg) begin
          commit        = 1'b1;
          wr_pulse_next = 1'b1;
          wr_idx_next   = lat_idx_reg;
          wr_data_next  = lat_wdata_reg;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      lat_idx_reg   <= '0;
      lat_write_reg <= 1'b0;
      lat_err_reg   <= 1'b0;
      lat_wdata_reg <= '0;
      PRDATA        <= '0;
      PREADY        <= 1'b0;
      PSLVERR       <= 1'b0;
      o_wr_pulse    <= 1'b0;
      o_wr_idx      <= '0;
      o_wr_data     <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      lat_idx_reg   <= lat_idx_next;
      lat_write_reg <= lat_write_next;
      lat_err_reg   <= lat_err_next;
      lat_wdata_reg <= lat_wdata_next;
      PRDATA        <= prdata_next;
      PREADY        <= pready_next;
      PSLVERR       <= pslverr_next;
      o_wr_pulse    <= wr_pulse_next;
      o_wr_idx      <= wr_idx_next;
      o_wr_data     <= wr_data_next;
    end
  end

  // Index 0 is never written (decode flags it), so it simply stays at zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (commit) begin
      regs_reg[lat_idx_reg[IDX_W-1:0]] <= lat_wdata_reg;
    end
  end

`ifdef FORMAL
`ifdef APB_MASTER_BOUND
`define APB_ASSUME assert
`else
`define APB_ASSUME assume
`endif
  m_en_needs_sel: `APB_ASSUME property (@(posedge i_clk) disable iff (!i_reset_n)
    PENABLE |-> PSELx);
  m_setup_to_access: `APB_ASSUME property (@(posedge i_clk) disable iff (!i_reset_n)
    PSELx && !PENABLE |=> PSELx && PENABLE);
  m_hold_until_ready: `APB_ASSUME property (@(posedge i_clk) disable iff (!i_reset_n)
    PSELx && PENABLE && !PREADY |=> PSELx && PENABLE);
  m_end_access: `APB_ASSUME property (@(posedge i_clk) disable iff (!i_reset_n)
    PSELx && PENABLE && PREADY |=> !PENABLE);

  p_pready_width: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    PREADY |=> !PREADY);
  p_pready_in_access: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    PREADY |-> PSELx && PENABLE);
  p_no_bad_write: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    o_wr_pulse |-> $past(PREADY && !PSLVERR && lat_write_reg));
`undef APB_ASSUME
`endif

endmodule
